// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed SRAM behind a request/ready handshake
// with programmable read latency and rejection of illegal requests.
module dmem_responder #(
  parameter int unsigned DEPTH        = 128,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [31:0]          dAddress,
  input  logic [31:0]          dWriteData,
  output logic [31:0]          dReadData,
  output logic                 mem_ready,
  output logic                 mem_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam int unsigned CNT_W      = 4;
  localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH * 4);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_RESP    = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 ready_q, ready_d;
  logic                 merr_q, merr_d;
  logic                 busy_q, busy_d;
  logic [ERR_CNT_W-1:0] errcnt_q, errcnt_d;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] widx_c;
  logic          bad_c;
  logic          we_c;

  assign widx_c = dAddress[AW+1:2];
  assign bad_c  = (MemRead & MemWrite) | (dAddress[1:0] != 2'b00) | (dAddress >= BYTE_LIMIT);

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rdata_d  = rdata_q;
    merr_d   = 1'b0;
    errcnt_d = errcnt_q;
    we_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (MemRead | MemWrite) begin
          if (bad_c) begin
            state_d = S_RESP;
            merr_d  = 1'b1;
            if (errcnt_q != {ERR_CNT_W{1'b1}}) begin
              errcnt_d = errcnt_q + ERR_CNT_W'(1);
            end
          end else if (MemWrite) begin
            we_c    = 1'b1;
            state_d = S_RESP;
          end else begin
            idx_d = widx_c;
            if (READ_LATENCY == 1) begin
              state_d = S_RESP;
              rdata_d = mem_q[widx_c];
            end else begin
              state_d = S_RD_WAIT;
              cnt_d   = CNT_W'(READ_LATENCY - 2);
            end
          end
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          rdata_d = mem_q[idx_q];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_HOLD;
      end
      default: begin
        // Wait for the core to drop its request so it is not accepted twice.
        if (!MemRead && !MemWrite) begin
          state_d = S_IDLE;
        end
      end
    endcase

    ready_d = (state_d == S_RESP);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      merr_q   <= 1'b0;
      busy_q   <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      merr_q   <= merr_d;
      busy_q   <= busy_d;
      errcnt_q <= errcnt_d;
    end
  end

  // Array contents survive reset; a write colliding with reset is dropped.
  always_ff @(posedge clk) begin
    if (we_c && !rst) begin
      mem_q[widx_c] <= dWriteData;
    end
  end

  assign dReadData = rdata_q;
  assign mem_ready = ready_q;
  assign mem_err   = merr_q;
  assign busy      = busy_q;
  assign err_count = errcnt_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the core's data-memory interface (MemRead/MemWrite/dAddress/dWriteData -> dReadData).
- Replaces the zero-wait RAM model with a word-addressed SRAM behind a request/ready handshake. Read latency is programmable; misaligned, out-of-range and conflicting requests are flagged.
- Sits between the multicycle core's MEM state and the data array. The core holds its request in MEM until mem_ready.

Parameters:
- DEPTH, 128, number of 32-bit words; legal byte addresses 0 .. DEPTH*4-1.
- READ_LATENCY, 2, cycles from request acceptance to read mem_ready; legal 1..8.
- ERR_CNT_W, 8, width of saturating error counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- MemRead  in  1  read request (level), held by core until mem_ready.
- MemWrite  in  1  write request (level), held by core until mem_ready.
- dAddress  in  32  byte address; word index = dAddress[$clog2(DEPTH)+1:2].
- dWriteData  in  32  store data, sampled at acceptance.
- dReadData  out  32  read data; valid when mem_ready and read completed.
- mem_ready  out  1  one-cycle completion pulse (read, write or error).
- mem_err  out  1  qualifies mem_ready: request rejected, no side effect.
- busy  out  1  high in any state other than IDLE.
- err_count  out  ERR_CNT_W  saturating count of rejected requests.

Behaviour:
- Reset (rst sampled high at posedge): state=IDLE, dReadData=0, mem_ready=0, mem_err=0, busy=0, err_count=0, latency counter=0. Array contents are NOT cleared. Reset overrides everything, including mid-read (response dropped). A write accepted before the reset edge stays committed.
- FSM states: IDLE, RD_WAIT, RESP, HOLD.
- IDLE: accept when MemRead|MemWrite=1. Error if any of the following, checked in this order:
  - MemRead&MemWrite both high.
  - dAddress[1:0]!=0.
  - dAddress >= DEPTH*4.
- Error path: no array access, next state RESP with mem_err=1. err_count increments, saturating at all-ones.
- Write accepted (no error): array[word] <= dWriteData on the acceptance edge. Next state RESP, so mem_ready is high in the cycle after acceptance (1-cycle write latency).
- Read accepted (no error): latch word index.
  - READ_LATENCY=1: go to RESP directly.
  - Otherwise: go to RD_WAIT with counter=READ_LATENCY-2, decrement each cycle, go to RESP when counter==0.
  - dReadData is loaded on the edge entering RESP.
  - Net: mem_ready rises exactly READ_LATENCY cycles after the acceptance edge.
- RESP: mem_ready=1 for exactly one cycle (mem_err=1 only for rejects). Always go to HOLD next.
- HOLD: ignore requests. Return to IDLE on the first cycle with MemRead=0 and MemWrite=0. This prevents re-accepting a request the core has not yet dropped. Minimum 1 cycle in HOLD.
- Request changes while in RD_WAIT: ignored. Address/data are captured at acceptance only.
- dReadData holds its last read value through writes, errors and idle. It changes only on a successful read.
- busy=1 in RD_WAIT, RESP, HOLD.
- Back-to-back throughput: accept, latency, RESP, HOLD, IDLE. Minimum READ_LATENCY+2 cycles per read and 3 per write.

Test Plan:
- Reset: hold rst 2 cycles with MemRead=1 -> mem_ready=0, busy=0, dReadData=0, err_count=0. Once released, the request is accepted on the next edge.
- Write 0xDEADBEEF to 0x04, drop MemWrite after mem_ready, then read 0x04 (READ_LATENCY=2) -> mem_ready exactly 2 cycles after the accept edge, dReadData=0xDEADBEEF, mem_err=0.
- Misaligned read 0x06, then out-of-range write 0x200 (DEPTH=128) -> each gives mem_ready=1 with mem_err=1, err_count=2, word 0x04 unchanged, dReadData unchanged.
- MemRead and MemWrite both high at 0x08 -> mem_err=1, no write. A subsequent read of 0x08 returns the prior value.
- Request held high through RESP for 3 extra cycles -> exactly one mem_ready pulse; busy stays high until the request drops, then IDLE.
- Assert rst during RD_WAIT of a read of 0x0C -> no mem_ready, dReadData=0. After a fresh read of 0x0C, earlier written contents are intact. Also run err_count saturation: 256 rejects with ERR_CNT_W=8 -> err_count stays at 0xFF.
